mem_ram_ctrl: RTL

- Synthesizable memory slave on the riscv core's native memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Sits directly downstream of the core and replaces the behavioural memory model in simulation and FPGA builds.
- Provides word-addressed RAM with byte-lane writes, configurable wait states, one halt/tohost MMIO register, and an error pulse for unmapped accesses.

---
 rtl/mem_ram_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_ram_ctrl.sv
// Memory slave for the core's native memory bus: word RAM with byte-lane writes,
// programmable wait states, a tohost halt register and a bus error for unmapped accesses.
module mem_ram_ctrl #(
  parameter int          WORDS       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int AW = $clog2(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [31:0] ram [WORDS];

  logic        accept, enter_resp;
  logic [29:0] acc_word;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic        ram_hit, mmio_hit;
  logic [AW-1:0] ram_idx;

  // Fetch/data distinction and the byte offset carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{mem_instr, mem_addr[1:0]};

  // Reset also blocks acceptance so nothing reaches the RAM while it is held.
  assign accept = (state == S_IDLE) && mem_valid && reset;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd1) state_n = S_RESP;
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign enter_resp = (state_n == S_RESP) && (state != S_RESP);

  // With zero wait states the access coincides with acceptance, so take the bus directly.
  assign acc_word  = (state == S_IDLE) ? mem_addr[31:2] : addr_q;
  assign acc_wdata = (state == S_IDLE) ? mem_wdata      : wdata_q;
  assign acc_wstrb = (state == S_IDLE) ? mem_wstrb      : wstrb_q;

  assign ram_hit  = (acc_word[29:AW] == '0);
  assign mmio_hit = !ram_hit && (acc_word == TOHOST_ADDR[31:2]);
  assign ram_idx  = acc_word[AW-1:0];

  assign mem_ready = (state == S_RESP);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      halt      <= 1'b0;
      halt_code <= '0;
    end else begin
      state   <= state_n;
      bus_err <= enter_resp && !ram_hit && !mmio_hit;

      if (accept) begin
        addr_q  <= mem_addr[31:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        cnt     <= WAIT_STATES[3:0];
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (enter_resp) begin
        if (ram_hit)       mem_rdata <= ram[ram_idx];
        else if (mmio_hit) mem_rdata <= {31'b0, halt};
        else               mem_rdata <= '0;

        if (mmio_hit && (acc_wstrb != 4'b0000)) begin
          halt <= 1'b1;
          if (!halt) halt_code <= acc_wdata;
        end
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset like real block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (enter_resp && ram_hit && acc_wstrb[i])
        ram[ram_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end
  end

endmodule
